note_judge_scheduler: RTL and testbench
=======================================

NOTE_JUDGE_SCHEDULER -- requirements
Module: note_judge_scheduler

Interface
REQ-001 Parameters SHALL be: NUM_NOTES, 4, number of note lanes; numBits, 10, Y width; CENTER, 10'h1F4, strike line Y; TOLERANCE, 10'h018, max distance from CENTER that counts as a hit.
REQ-002 frameClk  in  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  in  1  asynchronous, active-high.
REQ-004 timerActive  in  1  song running; strums ignored while low.
REQ-005 strum  in  1  raw strum level.
REQ-006 noteY  in  NUM_NOTES*numBits  packed note Y positions; lane i occupies bits [i*numBits +: numBits].
REQ-007 noteValid  in  NUM_NOTES  lane i holds a live note.
REQ-008 hitGrant  out  NUM_NOTES  one-hot, one-cycle pulse naming the lane that was hit.
REQ-009 addHit / addMiss  out  1 each  one-cycle judgement pulses; never high together.
REQ-010 hitScore  out  numBits+2  points of the last hit; held until the next hit.
REQ-011 totalScore  out  16  accumulated score; combo  out  8  consecutive-hit count.

Function
REQ-012 Strum edge: strumReg SHALL register strum; a new strum is strum=1 with strumReg=0.
REQ-013 FSM states SHALL be IDLE, JUDGE, HELD.
REQ-014 IDLE->JUDGE SHALL occur on the edge that samples a new strum while timerActive=1; while timerActive=0 new strums SHALL be ignored (no hit, no miss).
REQ-015 JUDGE SHALL last exactly one cycle and then go to HELD; HELD->IDLE SHALL occur on the first edge that samples strum=0.
REQ-016 Lane distance SHALL be |Y - CENTER|, computed in numBits+1 bits with no wrap-around.
REQ-017 A lane SHALL be a candidate when noteValid=1, distance <= TOLERANCE (inclusive), and its consumed flag is clear.
REQ-018 In JUDGE the candidate with the smallest distance SHALL win; on equal distance the lowest index SHALL win.
REQ-019 Latency: decision registered on the JUDGE->HELD edge; hitGrant, addHit and addMiss high for exactly the following cycle.
REQ-020 On a winner: hitGrant[i]=1, addHit=1, hitScore=(TOLERANCE-distance)*mult, totalScore += hitScore saturating at 16'hFFFF, combo += 1 saturating at 255, consumed[i] set.
REQ-021 With no candidate: addMiss=1, combo cleared to 0, totalScore and hitScore unchanged.
REQ-022 consumed[i] SHALL clear on the edge that samples lane i invalid or outside the window; a consumed note still in the window SHALL produce a miss.
REQ-023 A held strum SHALL produce exactly one judgement, however long it is held.

Reset
REQ-024 Reset SHALL asynchronously force: state IDLE; hitGrant, addHit, addMiss, hitScore, totalScore, combo, consumed all 0.
REQ-025 Reset SHALL set strumReg to 1, so a strum held through reset release is not a new strum.
REQ-026 Reset asserted in JUDGE or HELD SHALL suppress any pending pulse.

Configuration
REQ-027 With NOTE_COMBO_MULT_EN defined: mult = 1 + min(combo/8, 3), using combo before the increment (range 1..4).
REQ-028 Without NOTE_COMBO_MULT_EN: mult = 1, and the multiplier logic is not synthesized.

Structure
REQ-029 Package note_judge_pkg SHALL hold: the state enum; CENTER and TOLERANCE defaults; SCORE_W=16; COMBO_W=8.
REQ-030 Sub-module note_window_check SHALL compute per-lane distance and in-window, instantiated NUM_NOTES times; the min-select logic stays in the top module.

Verification
REQ-031 Lane0 Y=0x1F4 valid, strum 0->1 -> hitGrant=4'b0001 for 1 cycle two edges later, hitScore=24, totalScore=24, combo=1.
REQ-032 Lane1 Y=0x1F0 and lane2 Y=0x1FA -> grant 4'b0010, hitScore=20; with lane1 Y=0x1EF and lane2 Y=0x1F9 (both distance 5) -> grant 4'b0010.
REQ-033 Boundary, each with a fresh strum: Y=0x20C -> hit, hitScore=0; Y=0x20D -> addMiss; Y=0x3FF -> addMiss (distance 523, no wrap); after a miss combo=0.
REQ-034 Strum held 20 cycles on an in-window note -> one addHit; release and re-strum with the note still in window -> addMiss.
REQ-035 Reset pulsed in HELD with strum high -> all outputs 0; no pulse until strum drops and rises again. Strum with timerActive=0 -> no pulse.
REQ-036 NOTE_COMBO_MULT_EN: eight hits at distance 0 -> ninth hitScore=48, totalScore=240; without the macro -> ninth hitScore=24.

Source files
------------

// File: rtl/note_judge_pkg.sv
// Shared types and defaults for the note judge scheduler.
package note_judge_pkg;

    // Strum handling phases: waiting, deciding, waiting for strum release
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        JUDGE = 2'd1,
        HELD  = 2'd2
    } judgeState_t;

    localparam logic [9:0] CENTER_DEF    = 10'h1F4;
    localparam logic [9:0] TOLERANCE_DEF = 10'h018;
    localparam int         SCORE_W       = 16;
    localparam int         COMBO_W       = 8;

endpackage

// File: rtl/note_window_check.sv
// Per-lane distance from the strike line and in-window flag.
// Distance is |noteY - CENTER| formed one bit wider than Y, so it never wraps.
module note_window_check
    import note_judge_pkg::*;
#(
    parameter int                 numBits   = 10,
    parameter logic [numBits-1:0] CENTER    = CENTER_DEF,
    parameter logic [numBits-1:0] TOLERANCE = TOLERANCE_DEF
) (
    input  logic [numBits-1:0] noteY,
    output logic [numBits:0]   distance,
    output logic               inWindow
);

    // Subtract the smaller operand from the larger one to get the magnitude directly
    always_comb begin
        if (noteY >= CENTER) begin
            distance = {1'b0, noteY} - {1'b0, CENTER};
        end else begin
            distance = {1'b0, CENTER} - {1'b0, noteY};
        end
        inWindow = (distance <= {1'b0, TOLERANCE});
    end

endmodule

// File: rtl/note_judge_scheduler.sv
// Strum judge: turns each new strum into exactly one hit or miss judgement,
// picking the closest unconsumed note lane inside the strike window.
// Optional build macro NOTE_COMBO_MULT_EN enables the combo score multiplier
// (1 + min(combo/8, 3)); without it every hit scores at multiplier 1.
module note_judge_scheduler
    import note_judge_pkg::*;
#(
    parameter int                 NUM_NOTES = 4,
    parameter int                 numBits   = 10,
    parameter logic [numBits-1:0] CENTER    = CENTER_DEF,
    parameter logic [numBits-1:0] TOLERANCE = TOLERANCE_DEF
) (
    input  logic                         frameClk,
    input  logic                         Reset,
    input  logic                         timerActive,
    input  logic                         strum,
    input  logic [NUM_NOTES*numBits-1:0] noteY,
    input  logic [NUM_NOTES-1:0]         noteValid,
    output logic [NUM_NOTES-1:0]         hitGrant,
    output logic                         addHit,
    output logic                         addMiss,
    output logic [numBits+1:0]           hitScore,
    output logic [SCORE_W-1:0]           totalScore,
    output logic [COMBO_W-1:0]           combo
);

    judgeState_t              state;
    judgeState_t              stateNext;
    logic                     strumReg;
    logic                     newStrum;
    logic [numBits:0]         laneDist [NUM_NOTES];
    logic [NUM_NOTES-1:0]     laneInWin;
    logic [NUM_NOTES-1:0]     consumed;
    logic [NUM_NOTES-1:0]     candidate;
    logic                     anyCand;
    logic [NUM_NOTES-1:0]     winOneHot;
    logic [numBits:0]         winDist;
    logic [numBits:0]         baseScore;
    logic [numBits+1:0]       scoreNext;
    logic                     judgeNow;
    logic [NUM_NOTES-1:0]     consumeSet;

    // Saturating accumulate of a hit score into the running total
    function automatic logic [SCORE_W-1:0] satAddScore(input logic [SCORE_W-1:0] acc,
                                                       input logic [numBits+1:0] inc);
        logic [SCORE_W:0] sum;
        sum = {1'b0, acc} + (SCORE_W+1)'(inc);
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    // Saturating combo increment
    function automatic logic [COMBO_W-1:0] satIncCombo(input logic [COMBO_W-1:0] c);
        return (&c) ? c : c + COMBO_W'(1);
    endfunction

    for (genvar g = 0; g < NUM_NOTES; g++) begin : genLane
        note_window_check #(
            .numBits  (numBits),
            .CENTER   (CENTER),
            .TOLERANCE(TOLERANCE)
        ) uWindow (
            .noteY   (noteY[g*numBits +: numBits]),
            .distance(laneDist[g]),
            .inWindow(laneInWin[g])
        );
    end

    assign newStrum  = strum & ~strumReg;
    assign candidate = noteValid & laneInWin & ~consumed;
    assign judgeNow  = (state == JUDGE);

    // Strum level history; resets high so a strum held through reset is not new
    always_ff @(posedge frameClk or posedge Reset) begin
        if (Reset) begin
            strumReg <= 1'b1;
        end else begin
            strumReg <= strum;
        end
    end

    // State register
    always_ff @(posedge frameClk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state: accept a new strum only while the song runs, judge once, then wait for release
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (newStrum && timerActive) stateNext = JUDGE;
            JUDGE:   stateNext = HELD;
            HELD:    if (!strum) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Closest candidate wins; strict compare keeps the lowest index on ties
    always_comb begin
        anyCand   = 1'b0;
        winOneHot = '0;
        winDist   = '0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (candidate[i] && (!anyCand || (laneDist[i] < winDist))) begin
                anyCand      = 1'b1;
                winOneHot    = '0;
                winOneHot[i] = 1'b1;
                winDist      = laneDist[i];
            end
        end
    end

    // Base points shrink linearly with distance; winner distance never exceeds TOLERANCE
    always_comb baseScore = {1'b0, TOLERANCE} - winDist;

`ifdef NOTE_COMBO_MULT_EN
    logic [2:0] mult;

    // Multiplier from the combo before this hit: 1 + min(combo/8, 3)
    always_comb begin
        mult      = (combo >= COMBO_W'(24)) ? 3'd4 : (3'd1 + {1'b0, combo[4:3]});
        scoreNext = {1'b0, baseScore} * {{(numBits-1){1'b0}}, mult};
    end
`else
    // Fixed multiplier of one
    always_comb scoreNext = {1'b0, baseScore};
`endif

    // Judgement outputs: pulses last one cycle, scores and combo persist
    always_ff @(posedge frameClk or posedge Reset) begin
        if (Reset) begin
            hitGrant   <= '0;
            addHit     <= 1'b0;
            addMiss    <= 1'b0;
            hitScore   <= '0;
            totalScore <= '0;
            combo      <= '0;
        end else begin
            hitGrant <= '0;
            addHit   <= 1'b0;
            addMiss  <= 1'b0;
            if (judgeNow) begin
                if (anyCand) begin
                    hitGrant   <= winOneHot;
                    addHit     <= 1'b1;
                    hitScore   <= scoreNext;
                    totalScore <= satAddScore(totalScore, scoreNext);
                    combo      <= satIncCombo(combo);
                end else begin
                    addMiss <= 1'b1;
                    combo   <= '0;
                end
            end
        end
    end

    assign consumeSet = (judgeNow && anyCand) ? winOneHot : '0;

    // A hit note stays consumed until it leaves the window or goes invalid
    always_ff @(posedge frameClk or posedge Reset) begin
        if (Reset) begin
            consumed <= '0;
        end else begin
            consumed <= (consumed & noteValid & laneInWin) | consumeSet;
        end
    end

endmodule

// File: tb/tb_note_judge_scheduler.sv
// Bench for note_judge_scheduler: directed scenarios with literal expectations,
// then randomized strums/notes checked every cycle against a behavioural model.
// Honours NOTE_COMBO_MULT_EN the same way the design does.
module tb_note_judge_scheduler;

    localparam int NN       = 4;
    localparam int NB       = 10;
    localparam int CENTER_I = 500;
    localparam int TOL_I    = 24;

    logic                 frameClk = 1'b0;
    logic                 Reset;
    logic                 timerActive;
    logic                 strum;
    logic [NN*NB-1:0]     noteY;
    logic [NN-1:0]        noteValid;
    logic [NN-1:0]        hitGrant;
    logic                 addHit;
    logic                 addMiss;
    logic [NB+1:0]        hitScore;
    logic [15:0]          totalScore;
    logic [7:0]           combo;

    int vectors     = 0;
    int miscompares = 0;
    bit chkEn       = 1'b0;

    // Behavioural model state
    logic [NN-1:0] mGrant;
    bit            mHit;
    bit            mMiss;
    int            mScore;
    int            mTotal;
    int            mCombo;
    bit            mConsumed [NN];
    bit            mPrevStrum;
    bit            mBusy;
    int            edgeCount;
    int            acceptEdge;

    always #5 frameClk = ~frameClk;

    note_judge_scheduler dut (
        .frameClk   (frameClk),
        .Reset      (Reset),
        .timerActive(timerActive),
        .strum      (strum),
        .noteY      (noteY),
        .noteValid  (noteValid),
        .hitGrant   (hitGrant),
        .addHit     (addHit),
        .addMiss    (addMiss),
        .hitScore   (hitScore),
        .totalScore (totalScore),
        .combo      (combo)
    );

    function automatic int laneDist(int i);
        int y;
        y = int'(noteY[i*NB +: NB]);
        return (y > CENTER_I) ? (y - CENTER_I) : (CENTER_I - y);
    endfunction

    task automatic modelReset();
        mGrant     = '0;
        mHit       = 1'b0;
        mMiss      = 1'b0;
        mScore     = 0;
        mTotal     = 0;
        mCombo     = 0;
        mPrevStrum = 1'b1;
        mBusy      = 1'b0;
        edgeCount  = 0;
        acceptEdge = 0;
        for (int i = 0; i < NN; i++) mConsumed[i] = 1'b0;
    endtask

    // One rising edge of the model: judgement falls on the edge after an accepted strum
    task automatic modelStep();
        int best;
        int bestD;
        int d;
        int mult;
        if (Reset) begin
            modelReset();
            return;
        end
        edgeCount++;
        mGrant = '0;
        mHit   = 1'b0;
        mMiss  = 1'b0;
        if (mBusy && edgeCount == acceptEdge + 1) begin
            best  = -1;
            bestD = 0;
            for (int i = 0; i < NN; i++) begin
                d = laneDist(i);
                if (noteValid[i] && d <= TOL_I && !mConsumed[i] && (best < 0 || d < bestD)) begin
                    best  = i;
                    bestD = d;
                end
            end
            if (best >= 0) begin
`ifdef NOTE_COMBO_MULT_EN
                mult = 1 + (((mCombo / 8) > 3) ? 3 : (mCombo / 8));
`else
                mult = 1;
`endif
                mScore       = (TOL_I - bestD) * mult;
                mTotal       = (mTotal + mScore > 65535) ? 65535 : (mTotal + mScore);
                mCombo       = (mCombo < 255) ? (mCombo + 1) : 255;
                mGrant[best] = 1'b1;
                mHit         = 1'b1;
            end else begin
                mMiss  = 1'b1;
                mCombo = 0;
            end
        end
        for (int i = 0; i < NN; i++) begin
            if (mGrant[i]) mConsumed[i] = 1'b1;
            else if (!noteValid[i] || laneDist(i) > TOL_I) mConsumed[i] = 1'b0;
        end
        if (mBusy) begin
            if (edgeCount >= acceptEdge + 2 && !strum) mBusy = 1'b0;
        end else if (!mPrevStrum && strum && timerActive) begin
            mBusy      = 1'b1;
            acceptEdge = edgeCount;
        end
        mPrevStrum = strum;
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge frameClk) begin
        if (chkEn) begin
            vectors++;
            if (hitGrant !== mGrant) begin
                miscompares++;
                $display("FAIL cmp_hitGrant t=%0t got %b want %b", $time, hitGrant, mGrant);
            end
            if (addHit !== mHit) begin
                miscompares++;
                $display("FAIL cmp_addHit t=%0t got %b want %b", $time, addHit, mHit);
            end
            if (addMiss !== mMiss) begin
                miscompares++;
                $display("FAIL cmp_addMiss t=%0t got %b want %b", $time, addMiss, mMiss);
            end
            if (hitScore !== (NB+2)'(mScore)) begin
                miscompares++;
                $display("FAIL cmp_hitScore t=%0t got %0d want %0d", $time, hitScore, mScore);
            end
            if (totalScore !== 16'(mTotal)) begin
                miscompares++;
                $display("FAIL cmp_totalScore t=%0t got %0d want %0d", $time, totalScore, mTotal);
            end
            if (combo !== 8'(mCombo)) begin
                miscompares++;
                $display("FAIL cmp_combo t=%0t got %0d want %0d", $time, combo, mCombo);
            end
        end
    end

    task automatic checkLit(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge frameClk);
        modelStep();
        #2;
    endtask

    task automatic setLane(input int i, input int y, input bit v);
        noteY[i*NB +: NB] = NB'(y);
        noteValid[i]      = v;
    endtask

    // Strum rises; after return the judgement pulse is visible
    task automatic strumJudge();
        strum = 1'b1;
        tick();
        tick();
    endtask

    task automatic strumRelease();
        strum = 1'b0;
        tick();
        tick();
    endtask

    task automatic clearLanes();
        noteValid = '0;
        tick();
    endtask

    initial begin
        int pulses;
        int y;
        Reset       = 1'b1;
        timerActive = 1'b0;
        strum       = 1'b0;
        noteY       = '0;
        noteValid   = '0;
        modelReset();
        chkEn = 1'b1;
        tick();
        tick();
        checkLit("reset_hitGrant", int'(hitGrant), 0);
        checkLit("reset_totalScore", int'(totalScore), 0);
        checkLit("reset_combo", int'(combo), 0);
        Reset       = 1'b0;
        timerActive = 1'b1;
        tick();

        // Centered note on lane 0
        setLane(0, 'h1F4, 1'b1);
        strumJudge();
        checkLit("center_grant", int'(hitGrant), 1);
        checkLit("center_score", int'(hitScore), 24);
        checkLit("center_total", int'(totalScore), 24);
        checkLit("center_combo", int'(combo), 1);
        tick();
        checkLit("center_grant_one_cycle", int'(hitGrant), 0);
        strumRelease();
        clearLanes();

        // Closest lane wins
        setLane(1, 'h1F0, 1'b1);
        setLane(2, 'h1FA, 1'b1);
        strumJudge();
        checkLit("closest_grant", int'(hitGrant), 2);
        checkLit("closest_score", int'(hitScore), 20);
        strumRelease();
        clearLanes();

        // Tie goes to lower index
        setLane(1, 'h1EF, 1'b1);
        setLane(2, 'h1F9, 1'b1);
        strumJudge();
        checkLit("tie_grant", int'(hitGrant), 2);
        checkLit("tie_score", int'(hitScore), 19);
        strumRelease();
        clearLanes();

        // Window edge: inclusive hit scoring zero
        setLane(0, 'h20C, 1'b1);
        strumJudge();
        checkLit("edge_in_hit", int'(addHit), 1);
        checkLit("edge_in_score", int'(hitScore), 0);
        strumRelease();
        clearLanes();

        // Just outside the window
        setLane(0, 'h20D, 1'b1);
        strumJudge();
        checkLit("edge_out_miss", int'(addMiss), 1);
        checkLit("edge_out_combo", int'(combo), 0);
        strumRelease();
        clearLanes();

        // Far away, no wrap-around
        setLane(0, 'h3FF, 1'b1);
        strumJudge();
        checkLit("far_miss", int'(addMiss), 1);
        checkLit("far_no_hit", int'(addHit), 0);
        strumRelease();
        clearLanes();

        // Long hold gives one judgement; re-strum on the consumed note misses
        setLane(0, 'h1F4, 1'b1);
        strum  = 1'b1;
        pulses = 0;
        repeat (20) begin
            tick();
            pulses += int'(addHit);
        end
        checkLit("held_one_hit", pulses, 1);
        strumRelease();
        strumJudge();
        checkLit("consumed_miss", int'(addMiss), 1);
        strumRelease();
        clearLanes();

        // Reset while HELD with strum high
        setLane(0, 'h1F4, 1'b1);
        strum = 1'b1;
        tick();
        tick();
        tick();
        Reset = 1'b1;
        modelReset();
        #1;
        checkLit("rst_held_grant", int'(hitGrant), 0);
        checkLit("rst_held_total", int'(totalScore), 0);
        checkLit("rst_held_combo", int'(combo), 0);
        checkLit("rst_held_score", int'(hitScore), 0);
        tick();
        Reset  = 1'b0;
        pulses = 0;
        repeat (5) begin
            tick();
            pulses += int'(addHit) + int'(addMiss);
        end
        checkLit("rst_held_no_pulse", pulses, 0);
        strum = 1'b0;
        tick();
        strumJudge();
        checkLit("rst_restrum_hit", int'(addHit), 1);
        checkLit("rst_restrum_total", int'(totalScore), 24);
        strumRelease();
        clearLanes();

        // Song stopped: strum ignored
        timerActive = 1'b0;
        setLane(0, 'h1F4, 1'b1);
        strum  = 1'b1;
        pulses = 0;
        repeat (5) begin
            tick();
            pulses += int'(addHit) + int'(addMiss);
        end
        checkLit("timer_off_no_pulse", pulses, 0);
        strum = 1'b0;
        tick();
        timerActive = 1'b1;
        clearLanes();

        // Nine centered hits from a clean state
        Reset = 1'b1;
        modelReset();
        tick();
        Reset = 1'b0;
        tick();
        for (int k = 0; k < 9; k++) begin
            setLane(0, 'h1F4, 1'b1);
            strumJudge();
            if (k == 8) begin
                checkLit("ninth_combo_before", int'(combo), 9);
`ifdef NOTE_COMBO_MULT_EN
                checkLit("ninth_score", int'(hitScore), 48);
                checkLit("ninth_total", int'(totalScore), 240);
`else
                checkLit("ninth_score", int'(hitScore), 24);
                checkLit("ninth_total", int'(totalScore), 216);
`endif
            end
            strumRelease();
            clearLanes();
        end

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                Reset = 1'b1;
                modelReset();
                tick();
                Reset = 1'b0;
            end
            timerActive = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 3) == 0) strum = ~strum;
            for (int l = 0; l < NN; l++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 7) == 0) y = int'($urandom_range(0, 1023));
                    else y = CENTER_I - 30 + int'($urandom_range(0, 60));
                    setLane(l, y, ($urandom_range(0, 4) != 0));
                end
            end
            tick();
        end

        chkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
